// File: rtl/cr16_pkg.sv
// Shared CR16 datapath definitions.
// Holds the ALU opcode constants, the multiply/divide opcode constants,
// the PSR status bit indices shared by the ALU and the multiply/divide unit,
// and the multiply/divide sequencer state encoding.
package cr16_pkg;

  // Single-cycle ALU opcodes
  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_ADDC = 4'd1;
  localparam logic [3:0] ALU_OP_SUB  = 4'd2;
  localparam logic [3:0] ALU_OP_SUBC = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [3:0] ALU_OP_OR   = 4'd5;
  localparam logic [3:0] ALU_OP_XOR  = 4'd6;
  localparam logic [3:0] ALU_OP_CMP  = 4'd7;

  // Multiply/divide opcodes; 4..7 are invalid and complete with zero results
  localparam logic [2:0] MD_OP_MUL  = 3'd0;
  localparam logic [2:0] MD_OP_MULU = 3'd1;
  localparam logic [2:0] MD_OP_DIV  = 3'd2;
  localparam logic [2:0] MD_OP_DIVU = 3'd3;

  // PSR status bit positions
  localparam int STATUS_W              = 5;
  localparam int STATUS_INDEX_CARRY    = 0;
  localparam int STATUS_INDEX_LOW      = 1;
  localparam int STATUS_INDEX_FLAG     = 2;
  localparam int STATUS_INDEX_ZERO     = 3;
  localparam int STATUS_INDEX_NEGATIVE = 4;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_PREP = 2'd1,
    MD_ST_RUN  = 2'd2,
    MD_ST_FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/cr16_cond_negate.sv
// Conditional two's-complement negate.
// Ports:
//   value  - input operand
//   negate - when high, result = -value, otherwise result = value
//   result - output
module cr16_cond_negate
  import cr16_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic [P_WIDTH-1:0] value,
  input  logic               negate,
  output logic [P_WIDTH-1:0] result
);

  assign result = negate ? (~value + P_WIDTH'(1)) : value;

endmodule

// File: rtl/cr16_muldiv.sv
// CR16 multi-cycle multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction afterwards. Fixed latency: the start edge is edge 0,
// O_DONE pulses in the cycle after edge P_WIDTH+2.
// Ports:
//   I_CLK, I_RESET        - clock, synchronous active-high reset
//   I_START, I_OPCODE     - request and operation (sampled only when idle)
//   I_A, I_B              - multiplicand/divisor, multiplier/dividend
//   O_BUSY, O_DONE        - in-flight flag, one-cycle completion pulse
//   O_C, O_HI             - product low/high half, or quotient/remainder
//   O_STATUS              - PSR flags in the shared ALU bit layout
module cr16_muldiv
  import cr16_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic                I_START,
  input  logic [2:0]          I_OPCODE,
  input  logic [P_WIDTH-1:0]  I_A,
  input  logic [P_WIDTH-1:0]  I_B,
  output logic                O_BUSY,
  output logic                O_DONE,
  output logic [P_WIDTH-1:0]  O_C,
  output logic [P_WIDTH-1:0]  O_HI,
  output logic [STATUS_W-1:0] O_STATUS
);

  localparam int CNT_W = $clog2(P_WIDTH) + 1;
  localparam logic [P_WIDTH-1:0] MOST_NEG = {1'b1, {(P_WIDTH-1){1'b0}}};

  md_state_t            state;
  logic [2:0]           op_r;
  logic [P_WIDTH-1:0]   a_r, b_r;
  logic [P_WIDTH-1:0]   opnd_r;   // |multiplicand| or |divisor|
  logic [P_WIDTH-1:0]   hi_r;     // product high half / partial remainder
  logic [P_WIDTH-1:0]   lo_r;     // multiplier->product low / dividend->quotient
  logic                 res_neg_r, rem_neg_r;
  logic [CNT_W-1:0]     cnt_r;

  logic is_signed_op, is_div_op;
  assign is_signed_op = (op_r == MD_OP_MUL) || (op_r == MD_OP_DIV);
  assign is_div_op    = (op_r == MD_OP_DIV) || (op_r == MD_OP_DIVU);

  logic neg_a, neg_b;
  assign neg_a = is_signed_op & a_r[P_WIDTH-1];
  assign neg_b = is_signed_op & b_r[P_WIDTH-1];

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  logic [P_WIDTH-1:0] abs_a, abs_b;
  cr16_cond_negate #(.P_WIDTH(P_WIDTH)) u_abs_a (.value(a_r), .negate(neg_a), .result(abs_a));
  cr16_cond_negate #(.P_WIDTH(P_WIDTH)) u_abs_b (.value(b_r), .negate(neg_b), .result(abs_b));

  // One multiply step: conditionally add, then shift {carry,hi,lo} right.
  logic [P_WIDTH:0]   mul_sum;
  logic [P_WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  always_comb begin
    mul_sum = {1'b0, hi_r} + {1'b0, opnd_r};
    if (lo_r[0]) begin
      mul_hi_nxt = mul_sum[P_WIDTH:1];
      mul_lo_nxt = {mul_sum[0], lo_r[P_WIDTH-1:1]};
    end else begin
      mul_hi_nxt = {1'b0, hi_r[P_WIDTH-1:1]};
      mul_lo_nxt = {hi_r[0], lo_r[P_WIDTH-1:1]};
    end
  end

  // One restoring-divide step. The shifted remainder can reach 2*divisor-1,
  // so the trial subtraction carries two extra bits to expose the borrow.
  logic [P_WIDTH:0]   div_shift;
  logic [P_WIDTH+1:0] div_diff;
  logic               div_borrow;
  logic [P_WIDTH-1:0] div_hi_nxt, div_lo_nxt;
  always_comb begin
    div_shift  = {hi_r, lo_r[P_WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, opnd_r};
    div_borrow = div_diff[P_WIDTH+1];
    div_hi_nxt = div_borrow ? div_shift[P_WIDTH-1:0] : div_diff[P_WIDTH-1:0];
    div_lo_nxt = {lo_r[P_WIDTH-2:0], ~div_borrow};
  end

  // Result sign correction
  logic [2*P_WIDTH-1:0] prod_fix;
  logic [P_WIDTH-1:0]   quo_fix, rem_fix;
  cr16_cond_negate #(.P_WIDTH(2*P_WIDTH)) u_fix_prod (
    .value({hi_r, lo_r}), .negate(res_neg_r & (op_r == MD_OP_MUL)), .result(prod_fix));
  cr16_cond_negate #(.P_WIDTH(P_WIDTH)) u_fix_quo (
    .value(lo_r), .negate(res_neg_r & (op_r == MD_OP_DIV)), .result(quo_fix));
  cr16_cond_negate #(.P_WIDTH(P_WIDTH)) u_fix_rem (
    .value(hi_r), .negate(rem_neg_r & (op_r == MD_OP_DIV)), .result(rem_fix));

  logic div_zero, div_ovf;
  assign div_zero = (a_r == '0);
  assign div_ovf  = (op_r == MD_OP_DIV) && (b_r == MOST_NEG) && (a_r == '1);

  logic [P_WIDTH-1:0]  fix_c, fix_hi;
  logic [STATUS_W-1:0] fix_st;
  always_comb begin
    fix_c  = '0;
    fix_hi = '0;
    fix_st = '0;
    case (op_r)
      MD_OP_MUL: begin
        fix_c  = prod_fix[P_WIDTH-1:0];
        fix_hi = prod_fix[2*P_WIDTH-1:P_WIDTH];
        fix_st[STATUS_INDEX_FLAG]     = (fix_hi != {P_WIDTH{fix_c[P_WIDTH-1]}});
        fix_st[STATUS_INDEX_ZERO]     = (prod_fix == '0);
        fix_st[STATUS_INDEX_NEGATIVE] = fix_hi[P_WIDTH-1];
      end
      MD_OP_MULU: begin
        fix_c  = lo_r;
        fix_hi = hi_r;
        fix_st[STATUS_INDEX_CARRY] = (hi_r != '0);
        fix_st[STATUS_INDEX_ZERO]  = ({hi_r, lo_r} == '0);
      end
      MD_OP_DIV: begin
        if (div_zero) begin
          fix_c  = '1;
          fix_hi = b_r;
        end else if (div_ovf) begin
          fix_c  = MOST_NEG;
          fix_hi = '0;
        end else begin
          fix_c  = quo_fix;
          fix_hi = rem_fix;
        end
        fix_st[STATUS_INDEX_FLAG]     = div_zero | div_ovf;
        fix_st[STATUS_INDEX_ZERO]     = (fix_c == '0);
        fix_st[STATUS_INDEX_NEGATIVE] = fix_c[P_WIDTH-1];
      end
      MD_OP_DIVU: begin
        fix_c  = div_zero ? '1 : lo_r;
        fix_hi = div_zero ? b_r : hi_r;
        fix_st[STATUS_INDEX_FLAG] = div_zero;
        fix_st[STATUS_INDEX_ZERO] = (fix_c == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state     <= MD_ST_IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      opnd_r    <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      cnt_r     <= '0;
      O_BUSY    <= 1'b0;
      O_DONE    <= 1'b0;
      O_C       <= '0;
      O_HI      <= '0;
      O_STATUS  <= '0;
    end else begin
      O_DONE <= 1'b0;
      case (state)
        // Accept a request
        MD_ST_IDLE: begin
          if (I_START) begin
            op_r   <= I_OPCODE;
            a_r    <= I_A;
            b_r    <= I_B;
            O_BUSY <= 1'b1;
            state  <= MD_ST_PREP;
          end
        end
        // Load magnitudes and remember result/remainder signs
        MD_ST_PREP: begin
          hi_r      <= '0;
          lo_r      <= abs_b;
          opnd_r    <= abs_a;
          res_neg_r <= neg_a ^ neg_b;
          rem_neg_r <= neg_b;
          cnt_r     <= '0;
          state     <= MD_ST_RUN;
        end
        // P_WIDTH iterations
        MD_ST_RUN: begin
          if (is_div_op) begin
            hi_r <= div_hi_nxt;
            lo_r <= div_lo_nxt;
          end else begin
            hi_r <= mul_hi_nxt;
            lo_r <= mul_lo_nxt;
          end
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(P_WIDTH - 1)) begin
            state <= MD_ST_FIX;
          end
        end
        // Sign fix, overrides, publish results
        MD_ST_FIX: begin
          O_C      <= fix_c;
          O_HI     <= fix_hi;
          O_STATUS <= fix_st;
          O_DONE   <= 1'b1;
          O_BUSY   <= 1'b0;
          state    <= MD_ST_IDLE;
        end
        default: state <= MD_ST_IDLE;
      endcase
    end
  end

endmodule
